// File: rtl/store_buffer.sv
// Write-back store buffer: queues core word stores, drains them in order to data
// memory under a ready handshake, and forwards the youngest buffered word to loads.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_we,
   input  logic                    cpu_re,
   input  logic [AW-1:0]           cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic [31:0]             cpu_rdata,
   output logic                    stall_sb,
   output logic                    mem_we,
   output logic [AW-1:0]           mem_waddr,
   output logic [31:0]             mem_wdata,
   input  logic                    mem_ready,
   output logic [AW-1:0]           mem_raddr,
   input  logic [31:0]             mem_rdata,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-3:0]    addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_next;
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;
   logic             fwd_hit;
   logic [31:0]      fwd_data;
   logic [PW-1:0]    idx;
   logic             unused_addr_lsb;

   assign count           = count_q;
   assign mem_we          = (count_q != '0);
   assign stall_sb        = cpu_we && (count_q == FULL);
   assign push            = cpu_we && (count_q != FULL);
   assign pop             = mem_we && mem_ready;
   assign mem_waddr       = {addr_q[head_q], 2'b00};
   assign mem_wdata       = data_q[head_q];
   assign mem_raddr       = {cpu_addr[AW-1:2], 2'b00};
   assign unused_addr_lsb = ^cpu_addr[1:0];

   // A slot is never popped and pushed in the same cycle: that would need count 0 or full.
   always_comb begin
      valid_next = valid_q;
      if (pop) valid_next[head_q] = 1'b0;
      if (push) valid_next[tail_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         valid_q <= valid_next;
         if (pop) head_q <= head_q + PW'(1);
         if (push) tail_q <= tail_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= cpu_addr[AW-1:2];
         data_q[tail_q] <= cpu_wdata;
      end
   end

   // Walk oldest to youngest so the last match seen is the newest value of the word.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = mem_rdata;
      idx      = head_q;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if (valid_q[idx] && (addr_q[idx] == cpu_addr[AW-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
      cpu_rdata = (cpu_re && fwd_hit) ? fwd_data : mem_rdata;
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (reset) count_q <= FULL);
   a_no_underflow : assert property (@(posedge clk) disable iff (reset) !(pop && (count_q == '0)));

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a queue-based reference model.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_we, cpu_re, mem_ready;
   logic [AW-1:0] cpu_addr, mem_waddr, mem_raddr;
   logic [31:0]   cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
   logic          stall_sb, mem_we;
   logic [2:0]    count;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;
   ent_t q[$];

   int n_assert = 0;
   int n_fail   = 0;
   int dut_writes = 0;
   int stall_seen = 0;
   int w0;

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .stall_sb(stall_sb), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd_model();
      logic [31:0] r;
      logic        found;
      r = mem_rdata;
      found = 1'b0;
      if (cpu_re) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!found && (q[i].a[31:2] == cpu_addr[31:2])) begin
               r = q[i].d;
               found = 1'b1;
            end
         end
      end
      return r;
   endfunction

   // Compare all outputs with the model mid-cycle, while inputs are stable.
   task automatic settle();
      @(negedge clk);
      chk("count", 32'(count), 32'(q.size()));
      chk("mem_we", 32'(mem_we), 32'(q.size() != 0));
      chk("stall_sb", 32'(stall_sb), 32'(cpu_we && (q.size() == DEPTH)));
      chk("mem_raddr", mem_raddr, {cpu_addr[31:2], 2'b00});
      if (q.size() != 0) begin
         chk("mem_waddr", mem_waddr, q[0].a);
         chk("mem_wdata", mem_wdata, q[0].d);
      end
      if (!(cpu_we && cpu_re)) chk("cpu_rdata", cpu_rdata, fwd_model());
      if (mem_we && mem_ready) dut_writes++;
      if (stall_sb) stall_seen++;
   endtask

   task automatic tick();
      int sz;
      @(posedge clk);
      if (reset) begin
         q.delete();
      end else begin
         sz = q.size();
         if (sz != 0 && mem_ready) q.delete(0);
         if (cpu_we && sz < DEPTH) q.push_back('{a: {cpu_addr[31:2], 2'b00}, d: cpu_wdata});
      end
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_wdata = d;
      settle();
      tick();
   endtask

   initial begin
      reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; mem_ready = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      settle();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(stall_sb), 32'd0);
      tick();
      reset = 1'b0;

      // Basic drain
      mem_ready = 1'b1;
      store(32'h100, 32'hAAAA_0001);
      cpu_we = 1'b0;
      settle();
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", mem_waddr, 32'h100);
      chk("drain_data", mem_wdata, 32'hAAAA_0001);
      tick();
      settle();
      chk("drain_empty", 32'(count), 32'd0);
      tick();

      // Full stall
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hC000 + 32'(i));
      cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hC010;
      settle();
      chk("full_stall", 32'(stall_sb), 32'd1);
      chk("full_count", 32'(count), 32'd4);
      tick();
      mem_ready = 1'b1;
      settle();
      chk("full_nobypass", 32'(stall_sb), 32'd1);
      chk("full_head", mem_waddr, 32'h0);
      tick();
      mem_ready = 1'b0;
      settle();
      chk("full_release", 32'(stall_sb), 32'd0);
      tick();
      cpu_we = 1'b0;
      settle();
      chk("full_refill", 32'(count), 32'd4);
      chk("full_next_head", mem_waddr, 32'h4);
      tick();
      mem_ready = 1'b1;
      repeat (4) begin settle(); tick(); end
      settle();
      chk("full_drained", 32'(count), 32'd0);
      tick();

      // Youngest forwarding
      mem_ready = 1'b0;
      store(32'h200, 32'd1);
      store(32'h200, 32'd2);
      cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h202; mem_rdata = 32'h99;
      settle();
      chk("fwd_young", cpu_rdata, 32'd2);
      tick();
      cpu_addr = 32'h204; mem_rdata = 32'h55;
      settle();
      chk("fwd_miss", cpu_rdata, 32'h55);
      tick();

      // Simultaneous enqueue and pop
      cpu_re = 1'b0; mem_ready = 1'b1;
      store(32'h300, 32'd3);
      cpu_we = 1'b0; mem_ready = 1'b0;
      settle();
      chk("sim_count", 32'(count), 32'd2);
      chk("sim_head_addr", mem_waddr, 32'h200);
      chk("sim_head_data", mem_wdata, 32'd2);
      tick();
      mem_ready = 1'b1;
      repeat (2) begin settle(); tick(); end

      // Pointer wrap with continuous drain
      w0 = dut_writes;
      stall_seen = 0;
      for (int i = 0; i < 10; i++) store(32'h400 + 32'(4 * i), 32'hB000 + 32'(i));
      cpu_we = 1'b0;
      repeat (2) begin settle(); tick(); end
      chk("wrap_writes", 32'(dut_writes - w0), 32'd10);
      chk("wrap_nostall", 32'(stall_seen), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 2))
            0: begin cpu_we = 1'b1; cpu_re = 1'b0; end
            1: begin cpu_we = 1'b0; cpu_re = 1'b1; end
            default: begin cpu_we = 1'b0; cpu_re = 1'b0; end
         endcase
         cpu_addr  = {26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
         cpu_wdata = $urandom;
         mem_rdata = $urandom;
         mem_ready = ($urandom_range(0, 2) == 0);
         settle();
         tick();
      end
      cpu_we = 1'b0; cpu_re = 1'b0; mem_ready = 1'b1;
      repeat (DEPTH + 1) begin settle(); tick(); end

      // Asynchronous reset mid-operation
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) store(32'h500 + 32'(4 * i), 32'hD000 + 32'(i));
      cpu_we = 1'b0;
      settle();
      chk("mid_fill", 32'(count), 32'd3);
      tick();
      reset = 1'b1;
      q.delete();
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_mem_we", 32'(mem_we), 32'd0);
      settle();
      tick();
      reset = 1'b0;
      mem_ready = 1'b1;
      w0 = dut_writes;
      repeat (3) begin settle(); tick(); end
      chk("post_rst_writes", 32'(dut_writes - w0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
